register_file: RTL and testbench

// - Architectural register file plus rename (dependency) table. Receiving end of the ROB commit port.
// - Decode side: reports, per source register, either the committed value or the ROB id that will produce it.

---
 rtl/register_file_pkg.sv | 28 ++
 rtl/register_file_read_port.sv | 31 +++
 rtl/register_file.sv | 83 ++++++++
 tb/tb_register_file.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared widths, types and helpers for the register file and rename table.
package register_file_pkg;

  localparam int XLEN = 32;
  localparam int REG_CNT_WIDTH = 5;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int DEPENDENCY_WIDTH = ROB_SIZE_WIDTH + 1;
  localparam int REG_CNT = 1 << REG_CNT_WIDTH;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [REG_CNT_WIDTH-1:0] reg_t;
  typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;
  typedef logic [DEPENDENCY_WIDTH-1:0] dep_t;

  localparam dep_t NO_DEP = '1;

  typedef struct packed {
    logic    enable;
    reg_t    rd;
    word_t   val;
    rob_id_t id;
  } commit_t;

  function automatic dep_t rob_dep(input rob_id_t id);
    return {1'b0, id};
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: x0 handling and same-cycle commit bypass.
module register_file_read_port
  import register_file_pkg::*;
(
  input  reg_t    idx,
  input  word_t   vals [REG_CNT],
  input  dep_t    deps [REG_CNT],
  input  commit_t commit,
  output dep_t    dep,
  output word_t   val
);

  logic hit;

  assign hit = commit.enable
            && (commit.rd == idx)
            && (deps[idx] == rob_dep(commit.id));

  always_comb begin
    dep = deps[idx];
    val = vals[idx];
    if (idx == '0) begin
      dep = NO_DEP;
      val = '0;
    end else if (hit) begin
      dep = NO_DEP;
      val = commit.val;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename table; ROB commit port sink.
module register_file
  import register_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      stall,
  input  logic                      dec_ready,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rs1,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rs2,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
  input  logic                      dec_writes_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  input  logic                      rob_rf_enable,
  input  logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
  input  logic [XLEN-1:0]           rob_rf_val,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_rf_id,
  output logic [DEPENDENCY_WIDTH-1:0] rf_dep1,
  output logic [XLEN-1:0]           rf_val1,
  output logic [DEPENDENCY_WIDTH-1:0] rf_dep2,
  output logic [XLEN-1:0]           rf_val2
);

  word_t   vals [REG_CNT];
  dep_t    deps [REG_CNT];
  commit_t commit;
  logic    do_commit;
  logic    do_rename;

  assign commit = '{
    enable: rob_rf_enable,
    rd:     rob_rf_rd,
    val:    rob_rf_val,
    id:     rob_rf_id
  };

  assign do_commit = rob_rf_enable && (rob_rf_rd != '0);
  assign do_rename = !flush && !stall && dec_ready
                  && dec_writes_rd && (dec_rd != '0);

  // Later assignments win: flush over rename, rename over commit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        vals[i] <= '0;
        deps[i] <= NO_DEP;
      end
    end else if (rdy) begin
      if (do_commit) begin
        vals[rob_rf_rd] <= rob_rf_val;
        if (deps[rob_rf_rd] == rob_dep(rob_rf_id))
          deps[rob_rf_rd] <= NO_DEP;
      end
      if (flush) begin
        for (int i = 0; i < REG_CNT; i++)
          deps[i] <= NO_DEP;
      end else if (do_rename) begin
        deps[dec_rd] <= rob_dep(rob_tail_id);
      end
    end
  end

  register_file_read_port u_rp1 (
    .idx    (dec_rs1),
    .vals   (vals),
    .deps   (deps),
    .commit (commit),
    .dep    (rf_dep1),
    .val    (rf_val1)
  );

  register_file_read_port u_rp2 (
    .idx    (dec_rs2),
    .vals   (vals),
    .deps   (deps),
    .commit (commit),
    .dep    (rf_dep2),
    .val    (rf_val2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed scoreboard bench for register_file.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        flush;
  logic        stall;
  logic        dec_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_writes_rd;
  logic [3:0]  rob_tail_id;
  logic        rob_rf_enable;
  logic [4:0]  rob_rf_rd;
  logic [31:0] rob_rf_val;
  logic [3:0]  rob_rf_id;
  logic [4:0]  rf_dep1;
  logic [31:0] rf_val1;
  logic [4:0]  rf_dep2;
  logic [31:0] rf_val2;

  typedef struct {
    string       name;
    logic [4:0]  dep1;
    logic [31:0] val1;
    logic [4:0]  dep2;
    logic [31:0] val2;
  } exp_t;

  exp_t exp_q[$];
  logic probe = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .flush         (flush),
    .stall         (stall),
    .dec_ready     (dec_ready),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rd        (dec_rd),
    .dec_writes_rd (dec_writes_rd),
    .rob_tail_id   (rob_tail_id),
    .rob_rf_enable (rob_rf_enable),
    .rob_rf_rd     (rob_rf_rd),
    .rob_rf_val    (rob_rf_val),
    .rob_rf_id     (rob_rf_id),
    .rf_dep1       (rf_dep1),
    .rf_val1       (rf_val1),
    .rf_dep2       (rf_dep2),
    .rf_val2       (rf_val2)
  );

  // Monitor: compares presented read ports against queued expectations.
  always @(negedge clk) begin
    if (probe) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (rf_dep1 !== e.dep1 || rf_val1 !== e.val1 ||
            rf_dep2 !== e.dep2 || rf_val2 !== e.val2) begin
          errors++;
          $display("FAIL %s: got dep1=%h val1=%h dep2=%h val2=%h want dep1=%h val1=%h dep2=%h val2=%h",
                   e.name, rf_dep1, rf_val1, rf_dep2, rf_val2,
                   e.dep1, e.val1, e.dep2, e.val2);
        end
      end
    end
  end

  task automatic expect_rd(input string n, input logic [4:0] d1,
                           input logic [31:0] v1, input logic [4:0] d2,
                           input logic [31:0] v2);
    exp_t e;
    e.name = n;
    e.dep1 = d1;
    e.val1 = v1;
    e.dep2 = d2;
    e.val2 = v2;
    exp_q.push_back(e);
    probe = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    probe = 1'b0;
    dec_ready = 1'b0;
    dec_writes_rd = 1'b0;
    rob_rf_enable = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] tail);
    dec_ready = 1'b1;
    dec_writes_rd = 1'b1;
    dec_rd = rd;
    rob_tail_id = tail;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] id,
                        input logic [31:0] v);
    rob_rf_enable = 1'b1;
    rob_rf_rd = rd;
    rob_rf_id = id;
    rob_rf_val = v;
  endtask

  initial begin
    rst_n = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    dec_ready = 1'b0;
    dec_writes_rd = 1'b0;
    dec_rs1 = 5;
    dec_rs2 = 0;
    dec_rd = 0;
    rob_tail_id = 0;
    rob_rf_enable = 1'b0;
    rob_rf_rd = 0;
    rob_rf_val = 0;
    rob_rf_id = 0;
    @(posedge clk);
    #1;
    expect_rd("reset", 5'h1F, 0, 5'h1F, 0);
    step();
    rst_n = 1'b1;
    expect_rd("after_reset", 5'h1F, 0, 5'h1F, 0);
    step();

    rename(3, 2);
    dec_rs1 = 3;
    dec_rs2 = 3;
    expect_rd("rename_pre_map", 5'h1F, 0, 5'h1F, 0);
    step();
    dec_rs2 = 0;
    expect_rd("dep_x3_id2", 5'h02, 0, 5'h1F, 0);
    step();
    commit(3, 2, 32'hDEAD);
    expect_rd("commit_bypass", 5'h1F, 32'hDEAD, 5'h1F, 0);
    step();
    expect_rd("commit_stored", 5'h1F, 32'hDEAD, 5'h1F, 0);
    step();

    rename(3, 4);
    step();
    rename(3, 5);
    expect_rd("dep_x3_id4", 5'h04, 32'hDEAD, 5'h1F, 0);
    step();
    commit(3, 4, 7);
    expect_rd("old_commit_no_bypass", 5'h05, 32'hDEAD, 5'h1F, 0);
    step();
    expect_rd("old_commit_keeps_dep", 5'h05, 7, 5'h1F, 0);
    step();

    rename(6, 1);
    step();
    commit(6, 1, 32'h66);
    rename(6, 9);
    dec_rs2 = 6;
    expect_rd("commit_rename_bypass", 5'h05, 7, 5'h1F, 32'h66);
    step();
    expect_rd("rename_wins", 5'h05, 7, 5'h09, 32'h66);
    step();

    rename(1, 0);
    step();
    rename(2, 3);
    step();
    flush = 1'b1;
    commit(1, 0, 32'h80);
    rename(4, 7);
    dec_rs1 = 1;
    dec_rs2 = 2;
    expect_rd("flush_cycle", 5'h1F, 32'h80, 5'h03, 0);
    step();
    expect_rd("after_flush", 5'h1F, 32'h80, 5'h1F, 0);
    step();
    dec_rs1 = 4;
    dec_rs2 = 3;
    expect_rd("flush_blocks_rename", 5'h1F, 0, 5'h1F, 7);
    step();

    rdy = 1'b0;
    rename(5, 6);
    commit(6, 9, 32'h99);
    dec_rs1 = 5;
    dec_rs2 = 6;
    step();
    rdy = 1'b1;
    expect_rd("rdy_low_frozen", 5'h1F, 0, 5'h1F, 32'h66);
    step();
    stall = 1'b1;
    rename(5, 6);
    step();
    expect_rd("stall_blocks", 5'h1F, 0, 5'h1F, 32'h66);
    step();

    rename(0, 8);
    commit(0, 8, 32'h123);
    dec_rs1 = 0;
    dec_rs2 = 0;
    expect_rd("x0_cycle", 5'h1F, 0, 5'h1F, 0);
    step();
    expect_rd("x0_after", 5'h1F, 0, 5'h1F, 0);
    step();

    rename(7, 2);
    commit(3, 0, 32'h33);
    dec_rs1 = 3;
    dec_rs2 = 7;
    #1;
    rst_n = 1'b0;
    expect_rd("mid_reset", 5'h1F, 0, 5'h1F, 0);
    step();
    rst_n = 1'b1;
    expect_rd("post_mid_reset", 5'h1F, 0, 5'h1F, 0);
    step();
    step();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
